// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, reset PC and bubble word.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   // Word-align an address by clearing the byte-offset bits.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/Reg.sv
// Generic enable register with synchronous active-high reset to a fixed value.
module Reg #(
   parameter int          WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= RESET_VALUE;
      end else if (ena) begin
         data_out <= data_in;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, single-entry buffer,
// redirect flush with drain of an in-flight request.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// READY | buffer holds the instruction at pc, presented to IF/ID
// DRAIN | redirected mid-request; waiting to discard the stale response
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Fpc4,
   output logic [31:0] Finstruction,
   output logic        Fvalid,
   output logic        pc_ena_o
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_target;
   logic [31:0]  buffer;
   logic [31:0]  drain_addr;
   logic         pc_load;
   logic         presenting;

   assign pc_plus4        = pc + 32'd4;
   assign redirect_target = word_align(redirect_pc_i);

   always_comb begin
      pc_load = 1'b0;
      pc_next = pc;
      if (redirect_i) begin
         pc_load = 1'b1;
         pc_next = redirect_target;
      end else if ((state == READY) && !stall_i) begin
         pc_load = 1'b1;
         pc_next = pc_plus4;
      end
   end

   Reg #(
      .WIDTH       (32),
      .RESET_VALUE (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .ena      (pc_load),
      .data_in  (pc_next),
      .data_out (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         buffer     <= NOP_WORD;
         drain_addr <= RESET_PC;
      end else if (redirect_i) begin
         case (state)
            READY: begin
               state  <= FETCH;
               buffer <= NOP_WORD;
            end
            FETCH: begin
               // An ack in the redirect cycle completes the old request; its data is dropped.
               if (imem_ack) begin
                  state <= FETCH;
               end else begin
                  state      <= DRAIN;
                  drain_addr <= pc;
               end
            end
            DRAIN:   state <= DRAIN;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  buffer <= imem_rdata;
                  state  <= READY;
               end
            end
            READY: begin
               if (!stall_i) begin
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   // The stale request address stays on the bus in DRAIN while pc already holds the target.
   assign imem_req     = !rst && ((state == FETCH) || (state == DRAIN));
   assign imem_addr    = (state == DRAIN) ? drain_addr : pc;

   assign presenting   = !rst && !redirect_i && (state == READY);
   assign Fvalid       = presenting;
   assign Finstruction = presenting ? buffer : NOP_WORD;
   assign Fpc4         = pc_plus4;
   assign pc_ena_o     = ~stall_i;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of presented instructions.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Fpc4;
   logic [31:0] Finstruction;
   logic        Fvalid;
   logic        pc_ena_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t dropped;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .RESET_PC (RST_PC),
      .NOP_WORD (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .Fpc4          (Fpc4),
      .Finstruction  (Finstruction),
      .Fvalid        (Fvalid),
      .pc_ena_o      (pc_ena_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
      exp_t e;
      e.instr = instr;
      e.pc4   = pc4;
      exp_q.push_back(e);
   endtask

   // Compare a presented instruction against the scoreboard head; consume it when IF/ID loads.
   task automatic sb_check();
      exp_t e;
      if (Fvalid === 1'b1) begin
         chk_bit("sb_entry_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("sb_instr", Finstruction, e.instr);
            chk("sb_pc4", Fpc4, e.pc4);
            if (!stall_i) begin
               e = exp_q.pop_front();
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic a, input logic [31:0] d);
      @(posedge clk);
      #1;
      rst           = r;
      stall_i       = s;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      imem_ack      = a;
      imem_rdata    = d;
      #1;
      sb_check();
   endtask

   initial begin
      rst           = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;

      step(1, 0, 0, 32'h0, 0, 32'h0);
      step(1, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("reset_req", imem_req, 1'b0);
      chk_bit("reset_valid", Fvalid, 1'b0);
      chk("reset_instr", Finstruction, NOP);

      // Back-to-back fetches with the memory acking each request immediately.
      step(0, 0, 0, 32'h0, 1, 32'h0010_0093);
      chk_bit("seq0_req", imem_req, 1'b1);
      chk("seq0_addr", imem_addr, 32'h0040_0000);
      chk_bit("seq0_valid", Fvalid, 1'b0);
      chk("seq0_pc4_idle", Fpc4, 32'h0040_0004);
      push(32'h0010_0093, 32'h0040_0004);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("seq0_ready_valid", Fvalid, 1'b1);
      chk_bit("seq0_ready_req", imem_req, 1'b0);
      step(0, 0, 0, 32'h0, 1, 32'h0020_0113);
      chk("seq1_addr", imem_addr, 32'h0040_0004);
      chk_bit("seq1_valid", Fvalid, 1'b0);
      push(32'h0020_0113, 32'h0040_0008);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("seq1_ready_valid", Fvalid, 1'b1);
      step(0, 0, 0, 32'h0, 1, 32'h0030_0193);
      chk("seq2_addr", imem_addr, 32'h0040_0008);
      push(32'h0030_0193, 32'h0040_000C);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("seq2_ready_valid", Fvalid, 1'b1);

      // Stall held three cycles while READY.
      step(0, 0, 0, 32'h0, 1, 32'h8C01_0004);
      chk("stall_fetch_addr", imem_addr, 32'h0040_000C);
      push(32'h8C01_0004, 32'h0040_0010);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 32'h0, 0, 32'h0);
         chk_bit("stall_pc_ena", pc_ena_o, 1'b0);
         chk_bit("stall_no_req", imem_req, 1'b0);
         chk_bit("stall_valid", Fvalid, 1'b1);
         chk("stall_instr", Finstruction, 32'h8C01_0004);
         chk("stall_pc4", Fpc4, 32'h0040_0010);
      end
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("unstall_pc_ena", pc_ena_o, 1'b1);

      // Redirect in FETCH without ack: drain the stale request.
      step(0, 0, 1, 32'h0040_0103, 0, 32'h0);
      chk("redir_fetch_addr", imem_addr, 32'h0040_0010);
      chk_bit("redir_fetch_valid", Fvalid, 1'b0);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("drain_req", imem_req, 1'b1);
      chk("drain_stale_addr", imem_addr, 32'h0040_0010);
      step(0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
      chk("drain_ack_addr", imem_addr, 32'h0040_0010);
      chk_bit("drain_ack_valid", Fvalid, 1'b0);
      step(0, 0, 0, 32'h0, 1, 32'h0040_0213);
      chk("redir_target_addr", imem_addr, 32'h0040_0100);
      push(32'h0040_0213, 32'h0040_0104);

      // Redirect and stall together in READY: redirect wins, slot becomes a bubble.
      step(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
      chk_bit("redir_stall_valid", Fvalid, 1'b0);
      chk("redir_stall_instr", Finstruction, NOP);
      chk_bit("redir_stall_pc_ena", pc_ena_o, 1'b0);
      chk("flushed_entry_present", exp_q.size(), 32'd1);
      dropped = exp_q.pop_front();

      // Wrap at the top of the address space.
      step(0, 0, 0, 32'h0, 1, 32'h0050_0293);
      chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_fetch_pc4", Fpc4, 32'h0000_0000);
      push(32'h0050_0293, 32'h0000_0000);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("wrap_ready_valid", Fvalid, 1'b1);

      // Redirect in FETCH with a same-cycle ack: data dropped, refetch at target.
      step(0, 0, 1, 32'h0040_0200, 1, 32'hBAD0_0BAD);
      chk("wrap_next_addr", imem_addr, 32'h0000_0000);
      chk_bit("redir_ack_valid", Fvalid, 1'b0);
      step(0, 0, 1, 32'h0040_0300, 0, 32'h0);
      chk("redir_ack_target", imem_addr, 32'h0040_0200);
      chk_bit("redir_ack_req", imem_req, 1'b1);
      step(0, 0, 1, 32'h0040_0400, 0, 32'h0);
      chk("drain_redir_stale", imem_addr, 32'h0040_0200);
      chk("drain_redir_pc4", Fpc4, 32'h0040_0304);

      // Reset in DRAIN overrides redirect and ack.
      step(1, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("rst_drain_req", imem_req, 1'b0);
      chk_bit("rst_drain_valid", Fvalid, 1'b0);
      step(1, 1, 1, 32'h0040_0500, 1, 32'h1234_5678);
      chk_bit("rst_hold_req", imem_req, 1'b0);
      chk_bit("rst_hold_valid", Fvalid, 1'b0);
      step(0, 0, 0, 32'h0, 1, 32'h0060_0313);
      chk_bit("post_rst_req", imem_req, 1'b1);
      chk("post_rst_addr", imem_addr, RST_PC);
      push(32'h0060_0313, 32'h0040_0004);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_bit("post_rst_valid", Fvalid, 1'b1);

      chk("sb_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: address of the first fetch after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word driven when no valid instruction is presented.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall_i  input  1  hazard unit: IF/ID must hold this cycle.
REQ-006 redirect_i  input  1  branch/jump taken, resolved in ID.
REQ-007 redirect_pc_i  input  32  redirect target.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_ack  input  1  memory returns data this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-012 Fpc4  output  32  PC+4 of the presented instruction, to IF/ID.
REQ-013 Finstruction  output  32  presented instruction, to IF/ID.
REQ-014 Fvalid  output  1  Finstruction is a real fetched instruction.
REQ-015 pc_ena_o  output  1  load enable for the IF/ID register.

Function
REQ-016 The block SHALL hold a 32-bit pc, a 32-bit instruction buffer and a 3-state FSM: FETCH, READY, DRAIN.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack, capture imem_rdata and go to READY.
REQ-018 READY: Fvalid=1, Finstruction=buffer, Fpc4=pc+4; if stall_i=0, then pc<=pc+4 and go to FETCH; if stall_i=1, hold all state.
REQ-019 DRAIN: imem_req=1 with the stale address unchanged; on imem_ack, discard data and go to FETCH.
REQ-020 imem_req and imem_addr SHALL stay stable from assertion until the cycle of imem_ack.
REQ-021 redirect_i=1 SHALL have priority over stall_i and ack, and sets pc<=redirect_pc_i with bits [1:0] forced to 00.
REQ-022 Redirect state effects:
- in READY: drop the buffer, go to FETCH;
- in FETCH with imem_ack=1 the same cycle: drop the data, go to FETCH;
- in FETCH without ack: go to DRAIN;
- in DRAIN: update pc, stay in DRAIN.
REQ-023 Outside READY: Fvalid=0, Finstruction=NOP_WORD, Fpc4=pc+4.
REQ-024 During a redirect cycle, Fvalid SHALL be 0 and Finstruction=NOP_WORD, so the flushed slot becomes a bubble.
REQ-025 pc_ena_o SHALL equal ~stall_i; while a fetch is pending, IF/ID loads NOP bubbles.
REQ-026 PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 Minimum latency: ack in cycle N gives Fvalid=1 in cycle N+1. Peak throughput: one instruction per 2 cycles.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL load pc=RESET_PC, state=FETCH, buffer=NOP_WORD.
REQ-029 While rst=1, imem_req=0 and Fvalid=0; the first request to RESET_PC is issued in the cycle after rst falls.
REQ-030 rst SHALL override redirect_i, stall_i and imem_ack.
REQ-031 Reset during an outstanding request abandons it; the memory side is reset by the same rst.

Structure
REQ-032 Shared package cpu_pkg SHALL hold:
- the fetch-state enum;
- RESET_PC_DEFAULT;
- NOP_WORD.
REQ-033 The pc register SHALL be an instance of the codebase's existing enable register module Reg (clk, rst, ena, data_in, data_out).
REQ-034 The FSM and the instruction buffer SHALL be local to this module.

Verification
REQ-035 Reset then ack one cycle after each request:
- imem_addr sequence 0x00400000, 0x00400004, 0x00400008;
- Fpc4 = 0x00400004, 0x00400008, 0x0040000C;
- Fvalid high on alternate cycles.
REQ-036 stall_i held 3 cycles while READY with instruction 0x8C010004:
- Finstruction, Fpc4 and pc stay constant;
- pc_ena_o=0 for those 3 cycles;
- no new imem_req.
REQ-037 redirect_i=1 to 0x00400103 in FETCH with no ack:
- state goes to DRAIN;
- the stale address is held until ack, and that ack's data is discarded;
- the next request goes to 0x00400100.
REQ-038 redirect_i and stall_i both high in READY: redirect wins; next fetch at the target; Fvalid=0 in the redirect cycle.
REQ-039 Wrap: redirect to 0xFFFFFFFC, then ack: Fpc4=0x00000000, and the next imem_addr is 0x00000000.
REQ-040 rst asserted mid-DRAIN: the next cycle has imem_req=0 and Fvalid=0; the cycle after rst falls issues a request to RESET_PC.
